// File: rtl/mw_pipe_stage_if.sv
// Handshake and payload bundle for the memory/writeback pipeline register.
// The stage uses the slave modport; the producer/consumer side uses master.
interface mw_pipe_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCH    = 2,
  parameter int unsigned RD_W   = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  mwreg;
  logic                  mm2reg;
  logic [RD_W-1:0]       mrd;
  logic [NCH*DATA_W-1:0] mdata;
  logic                  out_valid;
  logic                  out_ready;
  logic                  wwreg;
  logic                  wm2reg;
  logic [RD_W-1:0]       wrd;
  logic [NCH*DATA_W-1:0] wdata;

  modport master (
    output in_valid, mwreg, mm2reg, mrd, mdata, out_ready,
    input  in_ready, out_valid, wwreg, wm2reg, wrd, wdata
  );

  modport slave (
    input  in_valid, mwreg, mm2reg, mrd, mdata, out_ready,
    output in_ready, out_valid, wwreg, wm2reg, wrd, wdata
  );
endinterface

// File: rtl/mw_pipe_stage.sv
// MEM/WB pipeline register with valid/ready flow control.
// Define MW_PIPE_STAGE_SKID_EN to add a one-entry skid buffer behind the output register.
module mw_pipe_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCH    = 2,
  parameter int unsigned RD_W   = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  mw_pipe_stage_if.slave bus,
  output logic [1:0]     count
);

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_t;

  occ_t state, state_nxt;
  logic accept, consume, load_out;
  logic o_wreg;

`ifdef MW_PIPE_STAGE_SKID_EN
  logic                  load_skid, skid_to_out;
  logic                  rdy_q;
  logic                  sk_wreg, sk_m2reg;
  logic [RD_W-1:0]       sk_rd;
  logic [NCH*DATA_W-1:0] sk_data;

  assign bus.in_ready = rdy_q;
`else
  assign bus.in_ready = bus.out_ready | ~bus.out_valid;
`endif

  assign bus.out_valid = (state != S_EMPTY);
  assign bus.wwreg     = o_wreg & bus.out_valid;
  assign count         = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
`ifdef MW_PIPE_STAGE_SKID_EN
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
`endif
    accept  = bus.in_valid & bus.in_ready;
    consume = bus.out_valid & bus.out_ready;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) begin
          load_out  = 1'b1;
          state_nxt = S_ONE;
        end
        S_ONE: if (consume) begin
          if (accept) load_out  = 1'b1;
          else        state_nxt = S_EMPTY;
        end
`ifdef MW_PIPE_STAGE_SKID_EN
        else if (accept) begin
          load_skid = 1'b1;
          state_nxt = S_FULL;
        end
        S_FULL: if (consume) begin
          skid_to_out = 1'b1;
          state_nxt   = S_ONE;
        end
`endif
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_wreg     <= 1'b0;
      bus.wm2reg <= 1'b0;
      bus.wrd    <= '0;
      bus.wdata  <= '0;
    end else if (load_out) begin
      o_wreg     <= bus.mwreg;
      bus.wm2reg <= bus.mm2reg;
      bus.wrd    <= bus.mrd;
      bus.wdata  <= bus.mdata;
    end
`ifdef MW_PIPE_STAGE_SKID_EN
    else if (skid_to_out) begin
      o_wreg     <= sk_wreg;
      bus.wm2reg <= sk_m2reg;
      bus.wrd    <= sk_rd;
      bus.wdata  <= sk_data;
    end
`endif
  end

`ifdef MW_PIPE_STAGE_SKID_EN
  // Registered ready: low exactly while the skid slot will be occupied.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rdy_q <= 1'b1;
    else        rdy_q <= (state_nxt != S_FULL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sk_wreg  <= 1'b0;
      sk_m2reg <= 1'b0;
      sk_rd    <= '0;
      sk_data  <= '0;
    end else if (load_skid) begin
      sk_wreg  <= bus.mwreg;
      sk_m2reg <= bus.mm2reg;
      sk_rd    <= bus.mrd;
      sk_data  <= bus.mdata;
    end
  end
`endif

endmodule

// File: doc/mw_pipe_stage.md
MW_PIPE_STAGE -- requirements
Module: mw_pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of one data channel.
REQ-002 Parameter NCH, default 2, number of data channels carried (result, memory data, ...).
REQ-003 Parameter RD_W, default 5, destination-register index width.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage accepts entry this cycle.
REQ-009 mwreg  input  1  register-write control.
REQ-010 mm2reg  input  1  memory-to-register select.
REQ-011 mrd  input  RD_W  destination register.
REQ-012 mdata  input  NCH*DATA_W  packed channels, channel k at bits [k*DATA_W +: DATA_W].
REQ-013 out_valid  output  1  held entry present.
REQ-014 out_ready  input  1  downstream consumes entry.
REQ-015 wwreg  output  1  qualified register-write enable.
REQ-016 wm2reg  output  1  registered mm2reg.
REQ-017 wrd  output  RD_W  registered mrd.
REQ-018 wdata  output  NCH*DATA_W  registered mdata.
REQ-019 count  output  2  entries held (0..2).

Function
REQ-020 Accept = in_valid & in_ready; consume = out_valid & out_ready; all state updates on rising clock.
REQ-021 Latency: entry accepted at edge N appears on outputs after edge N when the output register is empty or being consumed.
REQ-022 wwreg SHALL equal the stored write bit AND out_valid; a bubble never writes.
REQ-023 wm2reg, wrd, wdata SHALL hold their last value while out_valid=0.
REQ-024 Entries SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-025 out_valid=1 with out_ready=0: all outputs held stable.
REQ-026 flush=1: next cycle out_valid=0, skid empty, count=0; input accepted in the same cycle is dropped.
REQ-027 flush overrides simultaneous accept and consume.
REQ-028 count = out_valid + skid_valid.

Reset
REQ-029 reset=0 SHALL immediately clear out_valid, skid valid, wwreg, wm2reg, wrd, wdata, count to 0, independent of clock.
REQ-030 Reset asserted mid-transfer discards all entries; first accept after deassertion is the first entry out.
REQ-031 in_ready SHALL be 1 during reset and the first cycle after release when out_ready=1 (direct mode) or always (skid mode).

Configuration
REQ-032 Macro MW_PIPE_STAGE_SKID_EN compiles in a one-entry skid buffer.
REQ-033 Without macro: in_ready = out_ready | ~out_valid (combinational); count never exceeds 1.
REQ-034 With macro: in_ready = ~skid_valid, driven from a flop; entry accepted while output is held goes to skid; on consume, skid moves to output register (accept-into-output in same cycle if skid empty).
REQ-035 With macro, full (count=2) forces in_ready=0 next cycle; consume from full frees one slot the following cycle.

Verification
REQ-036 Reset: drive reset=0 mid-stream with out_valid=1 -> out_valid, wwreg, wrd, wdata, count all 0 before the next edge.
REQ-037 Flow: mwreg=1, mrd=5'd7, mdata={32'h1234_5678,32'hDEAD_BEEF}, in_valid=1, out_ready=1 -> one edge later out_valid=1, wwreg=1, wrd=7, wdata equals input.
REQ-038 Bubble: in_valid=0 for one cycle after REQ-037 -> out_valid=0, wwreg=0, wrd stays 7.
REQ-039 Stall: out_ready=0 for 3 cycles with entries A,B,C offered -> direct mode: A held, in_ready=0; skid mode: A held, B in skid, count=2, in_ready=0, C waits; release -> A,B,C in order.
REQ-040 Flush: flush=1 with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, offered entry never appears.
REQ-041 Random: 10k cycles random in_valid/out_ready/flush, scoreboard checks order, no loss without flush, wwreg=0 whenever out_valid=0.
